// File: rtl/serv_rf_seq.sv
// serv_rf_seq: bit-serial register-file sequencer.
// Reads rs1/rs2 from a W-bit two-port SRAM and streams them LSB first.
// Packs the serial rd result back into W-bit words for write-back.
// The RAM is expected to hold its read data until the next read strobe.
// Optional feature macro: SERV_RF_X0_GUARD_EN (x0 reads as zero, never written).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for i_rreq; the final rd word may still be written here
// ST_RD1    | reading word 0 of rs1
// ST_RD2    | reading word 0 of rs2, capturing rs1 word 0
// ST_RDY    | o_ready pulse, capturing rs2 word 0, clearing the bit counter
// ST_STREAM | 32 enabled bit cycles with prefetch of later words

module serv_rf_seq #(
  parameter int W = 2,
  localparam int AW = $clog2(1024 / W)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rreq,
  input  logic [4:0]    i_rs1_addr,
  input  logic [4:0]    i_rs2_addr,
  input  logic [4:0]    i_rd_addr,
  input  logic          i_cnt_en,
  input  logic          i_wen,
  input  logic          i_wdata,
  output logic          o_ready,
  output logic          o_rs1,
  output logic          o_rs2,
  output logic [AW-1:0] o_raddr,
  output logic          o_ren,
  input  logic [W-1:0]  i_rdata,
  output logic [AW-1:0] o_waddr,
  output logic [W-1:0]  o_wdata,
  output logic          o_wen
);

  localparam int NW = 32 / W;
  localparam int LW = $clog2(W);
  localparam logic [LW-1:0] POS_LAST = LW'(W - 1);
  localparam logic [LW-1:0] POS_PRE  = LW'(W - 2);
  localparam logic [4:0]    K_LAST   = 5'(NW - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD1,
    ST_RD2,
    ST_RDY,
    ST_STREAM
  } state_e;

  state_e state_q, state_d;

  logic [4:0]   rs1_a_q, rs1_a_d;
  logic [4:0]   rs2_a_q, rs2_a_d;
  logic [4:0]   rd_a_q, rd_a_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [W-1:0] rs1_sr_q, rs1_sr_d;
  logic [W-1:0] rs2_sr_q, rs2_sr_d;
  logic [W-1:0] wbuf_q, wbuf_d;
  logic         wen_st_q, wen_st_d;
  logic         ready_q, ready_d;
  logic         wr_pend_q, wr_pend_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [W-1:0]  wdata_q, wdata_d;

  logic [LW-1:0] bpos;
  logic [4:0]    widx;
  logic          step_en;
  logic          at_last;
  logic          at_pre;
  logic          at_wb;
  logic          more;
  logic          rs1_kill;
  logic          rs2_kill;
  logic          rd_kill;

  // RAM word address: register number in the upper bits, word index below.
  function automatic logic [AW-1:0] mk_addr(input logic [4:0] r, input logic [4:0] k);
    logic [9:0] full;
    full = ({r, 5'd0} >> LW) | {5'd0, k};
    return full[AW-1:0];
  endfunction

  assign bpos    = cnt_q[LW-1:0];
  assign widx    = cnt_q >> LW;
  assign step_en = (state_q == ST_STREAM) && i_cnt_en;
  assign at_last = (bpos == POS_LAST);
  assign at_pre  = (bpos == POS_PRE);
  assign at_wb   = (bpos == '0) && (cnt_q != 5'd0);
  assign more    = (widx != K_LAST);

`ifdef SERV_RF_X0_GUARD_EN
  assign rs1_kill = (rs1_a_q == 5'd0);
  assign rs2_kill = (rs2_a_q == 5'd0);
  assign rd_kill  = (rd_a_q == 5'd0);
`else
  assign rs1_kill = 1'b0;
  assign rs2_kill = 1'b0;
  assign rd_kill  = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; i_rreq only matters in idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_rreq) state_d = ST_RD1;
      ST_RD1:    state_d = ST_RD2;
      ST_RD2:    state_d = ST_RDY;
      ST_RDY:    state_d = ST_STREAM;
      ST_STREAM: if (i_cnt_en && (cnt_q == 5'd31)) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: address latch, shift registers, counter, write packer.
  always_comb begin
    rs1_a_d   = rs1_a_q;
    rs2_a_d   = rs2_a_q;
    rd_a_d    = rd_a_q;
    cnt_d     = cnt_q;
    rs1_sr_d  = rs1_sr_q;
    rs2_sr_d  = rs2_sr_q;
    wbuf_d    = wbuf_q;
    wen_st_d  = wen_st_q;
    ready_d   = (state_d == ST_RDY);
    wr_pend_d = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    if ((state_q == ST_IDLE) && i_rreq) begin
      rs1_a_d = i_rs1_addr;
      rs2_a_d = i_rs2_addr;
      rd_a_d  = i_rd_addr;
    end

    if (state_q == ST_RD2) begin
      rs1_sr_d = i_rdata;
    end

    if (state_q == ST_RDY) begin
      rs2_sr_d = i_rdata;
      cnt_d    = 5'd0;
    end

    if (step_en) begin
      cnt_d    = cnt_q + 5'd1;
      rs1_sr_d = rs1_sr_q >> 1;
      rs2_sr_d = rs2_sr_q >> 1;
      // rs1 word k+1 arrives from the read issued one bit earlier.
      if (at_last && more) begin
        rs1_sr_d = i_rdata;
      end
      // rs2 word k+1 arrives just in time: bit 0 goes straight out, rest is kept.
      if (at_wb) begin
        rs2_sr_d = i_rdata >> 1;
      end
      wbuf_d[bpos] = i_wdata;
      if (at_last) begin
        wen_st_d  = 1'b0;
        wr_pend_d = (wen_st_q | i_wen) & ~rd_kill;
        waddr_d   = mk_addr(rd_a_q, widx);
        wdata_d   = wbuf_d;
      end else begin
        wen_st_d = wen_st_q | i_wen;
      end
    end
  end

  // Datapath registers; reset also drops any pending write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs1_a_q   <= 5'd0;
      rs2_a_q   <= 5'd0;
      rd_a_q    <= 5'd0;
      cnt_q     <= 5'd0;
      rs1_sr_q  <= '0;
      rs2_sr_q  <= '0;
      wbuf_q    <= '0;
      wen_st_q  <= 1'b0;
      ready_q   <= 1'b0;
      wr_pend_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      rs1_a_q   <= rs1_a_d;
      rs2_a_q   <= rs2_a_d;
      rd_a_q    <= rd_a_d;
      cnt_q     <= cnt_d;
      rs1_sr_q  <= rs1_sr_d;
      rs2_sr_q  <= rs2_sr_d;
      wbuf_q    <= wbuf_d;
      wen_st_q  <= wen_st_d;
      ready_q   <= ready_d;
      wr_pend_q <= wr_pend_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Read strobes, read address and serial outputs per state.
  always_comb begin
    o_ren   = 1'b0;
    o_raddr = '0;
    o_rs1   = 1'b0;
    o_rs2   = 1'b0;
    case (state_q)
      ST_RD1: begin
        o_ren   = 1'b1;
        o_raddr = mk_addr(rs1_a_q, 5'd0);
      end
      ST_RD2: begin
        o_ren   = 1'b1;
        o_raddr = mk_addr(rs2_a_q, 5'd0);
      end
      ST_STREAM: begin
        o_rs1 = rs1_sr_q[0] & ~rs1_kill;
        o_rs2 = (at_wb ? i_rdata[0] : rs2_sr_q[0]) & ~rs2_kill;
        if (i_cnt_en && more) begin
          if (at_pre) begin
            o_ren   = 1'b1;
            o_raddr = mk_addr(rs1_a_q, widx + 5'd1);
          end else if (at_last) begin
            o_ren   = 1'b1;
            o_raddr = mk_addr(rs2_a_q, widx + 5'd1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign o_ready = ready_q;
  assign o_wen   = wr_pend_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;

endmodule

// File: tb/tb_serv_rf_seq.sv
// Testbench for serv_rf_seq at W=4 with a behavioural read-before-write RAM.
module tb_serv_rf_seq;
  localparam int W  = 4;
  localparam int NW = 32 / W;
  localparam int AW = $clog2(1024 / W);

  logic          clk;
  logic          rst_n;
  logic          i_rreq;
  logic [4:0]    i_rs1_addr;
  logic [4:0]    i_rs2_addr;
  logic [4:0]    i_rd_addr;
  logic          i_cnt_en;
  logic          i_wen;
  logic          i_wdata;
  logic          o_ready;
  logic          o_rs1;
  logic          o_rs2;
  logic [AW-1:0] o_raddr;
  logic          o_ren;
  logic [W-1:0]  i_rdata;
  logic [AW-1:0] o_waddr;
  logic [W-1:0]  o_wdata;
  logic          o_wen;

  serv_rf_seq #(.W(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rreq     (i_rreq),
    .i_rs1_addr (i_rs1_addr),
    .i_rs2_addr (i_rs2_addr),
    .i_rd_addr  (i_rd_addr),
    .i_cnt_en   (i_cnt_en),
    .i_wen      (i_wen),
    .i_wdata    (i_wdata),
    .o_ready    (o_ready),
    .o_rs1      (o_rs1),
    .o_rs2      (o_rs2),
    .o_raddr    (o_raddr),
    .o_ren      (o_ren),
    .i_rdata    (i_rdata),
    .o_waddr    (o_waddr),
    .o_wdata    (o_wdata),
    .o_wen      (o_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, old_rd, wv, wmask, stall;
    logic [31:0] exp1, exp2, exp_rd;
    int          exp_nwr;
    logic        exp_fin;
  } vec_t;

  logic [W-1:0]  mem [0:(1<<AW)-1];
  int            checks = 0;
  int            errors = 0;
  logic          s_ready, s_rs1, s_rs2, s_ren, s_wen;
  logic [AW-1:0] s_raddr, s_waddr;
  logic [W-1:0]  s_wdata;
  logic [AW-1:0] wa [0:15];
  logic [W-1:0]  wd [0:15];
  int            t_bad, t_nwr, t_lat;
  logic          t_fin;
  logic [31:0]   g1, g2;
  vec_t          vecs [0:4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    for (int k = 0; k < NW; k++) mem[int'(r) * NW + k] = v[k*W +: W];
  endtask

  function automatic logic [31:0] get_reg(input logic [4:0] r);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[k*W +: W] = mem[int'(r) * NW + k];
    return v;
  endfunction

  // One clock: drive at negedge, sample shortly after, model the RAM at posedge.
  task automatic step(input logic en, input logic we, input logic wdi, input logic rq);
    logic [W-1:0] rnext;
    @(negedge clk);
    i_cnt_en = en;
    i_wen    = we;
    i_wdata  = wdi;
    i_rreq   = rq;
    #2;
    s_ready = o_ready;
    s_rs1   = o_rs1;
    s_rs2   = o_rs2;
    s_ren   = o_ren;
    s_raddr = o_raddr;
    s_wen   = o_wen;
    s_waddr = o_waddr;
    s_wdata = o_wdata;
    rnext = o_ren ? mem[o_raddr] : i_rdata;
    if (o_wen) mem[o_waddr] = o_wdata;
    @(posedge clk);
    #1 i_rdata = rnext;
  endtask

  task automatic rec_wr();
    if (s_wen) begin
      if (t_nwr < 16) begin
        wa[t_nwr] = s_waddr;
        wd[t_nwr] = s_wdata;
      end
      t_nwr++;
    end
  endtask

  // Per stream cycle: reads only at bit W-2 / W-1 of a non-final word, no stray ready.
  task automatic note(input int b, input logic en, input logic [4:0] r1, input logic [4:0] r2);
    logic exp_ren;
    int   ea;
    exp_ren = en && ((b % W) >= W - 2) && ((b / W) < NW - 1);
    if (s_ren !== exp_ren) t_bad++;
    else if (s_ren) begin
      ea = (((b % W) == W - 2) ? int'(r1) : int'(r2)) * NW + b / W + 1;
      if (int'(s_raddr) != ea) t_bad++;
    end
    if (s_ready) t_bad++;
    rec_wr();
  endtask

  task automatic wait_ready(output int lat);
    lat = -1;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (s_ready) lat = c;
    end
  endtask

  task automatic run_txn(input vec_t v, input logic chain_in, input logic chain_out,
                         input logic [4:0] n1, input logic [4:0] n2, input logic [4:0] nd);
    g1 = '0; g2 = '0; t_bad = 0; t_nwr = 0; t_fin = 1'b0;
    if (!chain_in) begin
      i_rs1_addr = v.rs1; i_rs2_addr = v.rs2; i_rd_addr = v.rd;
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    wait_ready(t_lat);
    for (int b = 0; b < 32; b++) begin
      if (v.stall[b]) begin
        repeat (2) begin
          step(1'b0, 1'b0, 1'b0, 1'b0);
          note(b, 1'b0, v.rs1, v.rs2);
        end
      end
      step(1'b1, v.wmask[b], v.wv[b], 1'b0);
      note(b, 1'b1, v.rs1, v.rs2);
      g1[b] = s_rs1;
      g2[b] = s_rs2;
    end
    if (chain_out) begin
      i_rs1_addr = n1; i_rs2_addr = n2; i_rd_addr = nd;
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    t_fin = s_wen;
    rec_wr();
    if (!chain_out) begin
      repeat (2) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rec_wr();
        if (s_ready) t_bad++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        hv, hb;
    logic [3:0]  nib [0:7];
    int          viol;

    rst_n = 1'b1;
    i_rreq = 1'b0; i_rs1_addr = '0; i_rs2_addr = '0; i_rd_addr = '0;
    i_cnt_en = 1'b0; i_wen = 1'b0; i_wdata = 1'b0; i_rdata = '0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_outputs", 64'({o_ready, o_rs1, o_rs2, o_ren, o_raddr, o_wen, o_waddr, o_wdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //          rs1    rs2    rd     v1            v2            old_rd        wv            wmask         stall         exp1          exp2          exp_rd     nwr fin
    vecs[0] = '{5'd5,  5'd6,  5'd7,  32'hA5A50F0F, 32'h12345678, 32'h11111111, 32'h00000000, 32'h00000000, 32'h00000000, 32'hA5A50F0F, 32'h12345678, 32'h11111111, 0, 1'b0};
    vecs[1] = '{5'd10, 5'd11, 5'd12, 32'hCAFEBABE, 32'h0F1E2D3C, 32'h00000000, 32'h13579BDF, 32'hFFFFFFFF, 32'h80418199, 32'hCAFEBABE, 32'h0F1E2D3C, 32'h13579BDF, 8, 1'b1};
    vecs[2] = '{5'd20, 5'd20, 5'd21, 32'h80000001, 32'h80000001, 32'h22222222, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h80000001, 32'h80000001, 32'h22222222, 0, 1'b0};
`ifdef SERV_RF_X0_GUARD_EN
    vecs[3] = '{5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 1'b0};
`else
    vecs[3] = '{5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 8, 1'b1};
`endif
    vecs[4] = '{5'd13, 5'd14, 5'd15, 32'h00000000, 32'h00000000, 32'h00000000, 32'hABCDEF12, 32'h00F00001, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00C00002, 2, 1'b0};

    for (int i = 0; i < 5; i++) begin
      set_reg(vecs[i].rd, vecs[i].old_rd);
      set_reg(vecs[i].rs1, vecs[i].v1);
      set_reg(vecs[i].rs2, vecs[i].v2);
      run_txn(vecs[i], 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk($sformatf("v%0d_ready_latency", i), 64'(t_lat), 64'd3);
      chk($sformatf("v%0d_rs1", i), 64'(g1), 64'(vecs[i].exp1));
      chk($sformatf("v%0d_rs2", i), 64'(g2), 64'(vecs[i].exp2));
      chk($sformatf("v%0d_read_pattern", i), 64'(t_bad), 64'd0);
      chk($sformatf("v%0d_write_count", i), 64'(t_nwr), 64'(vecs[i].exp_nwr));
      chk($sformatf("v%0d_final_write", i), 64'(t_fin), 64'(vecs[i].exp_fin));
      chk($sformatf("v%0d_rd_in_ram", i), 64'(get_reg(vecs[i].rd)), 64'(vecs[i].exp_rd));
    end

    // Write-back of 0xDEADBEEF to x9: eight nibble writes in address order.
    nib[0] = 4'hF; nib[1] = 4'hE; nib[2] = 4'hE; nib[3] = 4'hB;
    nib[4] = 4'hD; nib[5] = 4'hA; nib[6] = 4'hE; nib[7] = 4'hD;
    hv = '{5'd1, 5'd2, 5'd9, 32'h0000FFFF, 32'hFFFF0000, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0,
           32'h0, 32'h0, 32'h0, 0, 1'b0};
    set_reg(5'd9, 32'h0); set_reg(5'd1, hv.v1); set_reg(5'd2, hv.v2);
    run_txn(hv, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("wb_count", 64'(t_nwr), 64'd8);
    chk("wb_final_gap", 64'(t_fin), 64'd1);
    chk("wb_rs1", 64'(g1), 64'h0000FFFF);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("wb_addr%0d", j), 64'(wa[j]), 64'(9 * NW + j));
      chk($sformatf("wb_data%0d", j), 64'(wd[j]), 64'(nib[j]));
    end

    // Back-to-back: final write of x3 lands in the same cycle as the next request.
    set_reg(5'd3, 32'hFFFFFFFF); set_reg(5'd4, 32'h0000AAAA); set_reg(5'd5, 32'h0);
    hv = '{5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 32'h00000055, 32'hFFFFFFFF, 32'h0,
           32'h0, 32'h0, 32'h0, 0, 1'b0};
    hb = '{5'd3, 5'd4, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
           32'h0, 32'h0, 32'h0, 0, 1'b0};
    run_txn(hv, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5);
    chk("b2b_first_final_write", 64'(t_fin), 64'd1);
    run_txn(hb, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    chk("b2b_ready_latency", 64'(t_lat), 64'd3);
    chk("b2b_rs1_fresh", 64'(g1), 64'h00000055);
    chk("b2b_rs2", 64'(g2), 64'h0000AAAA);

    // Asynchronous reset at bit 13: outputs drop at once, partial word is discarded.
    set_reg(5'd8, 32'h0); set_reg(5'd10, 32'hFFFFFFFF); set_reg(5'd11, 32'hFFFFFFFF);
    i_rs1_addr = 5'd10; i_rs2_addr = 5'd11; i_rd_addr = 5'd8;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    wait_ready(t_lat);
    chk("mid_ready_latency", 64'(t_lat), 64'd3);
    for (int b = 0; b < 13; b++) step(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    i_cnt_en = 1'b1; i_wen = 1'b1; i_wdata = 1'b1;
    #2;
    chk("mid_rs1_live", 64'(o_rs1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 64'({o_ready, o_rs1, o_rs2, o_ren, o_raddr, o_wen, o_waddr, o_wdata}), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (s_wen || s_ready || s_ren || s_rs1 || s_rs2) viol++;
    end
    chk("post_reset_quiet", 64'(viol), 64'd0);
    chk("mid_rd_partial", 64'(get_reg(5'd8)), 64'h00000FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serv_rf_seq.md
# serv_rf_seq

Bit-serial register-file sequencer between a word-wide two-port register SRAM and the core's state/control logic. On each read request it:
- fetches the first rs1/rs2 words;
- pulses the ready signal consumed by the core state machine;
- streams rs1/rs2 one bit per counted cycle, prefetching later words;
- packs the serial rd result into W-bit words for write-back.

## Interface
- W, default 2: RAM data width; legal 2, 4, 8, 16, 32.
- AW, derived = $clog2(1024/W): RAM word address width.

Ports:
- i_clk  in  1  core clock; all state on rising edge
- i_rst_n  in  1  asynchronous reset, active low
- i_rreq  in  1  start register read for current instruction/stage
- i_rs1_addr  in  5  source register 1
- i_rs2_addr  in  5  source register 2
- i_rd_addr  in  5  destination register
- i_cnt_en  in  1  bit-cycle enable from state machine (32 cycles per pass)
- i_wen  in  1  rd write enable, valid with i_cnt_en
- i_wdata  in  1  rd serial data, LSB first
- o_ready  out  1  one-cycle pulse: first words loaded, streaming may start
- o_rs1  out  1  rs1 serial bit, LSB first
- o_rs2  out  1  rs2 serial bit, LSB first
- o_raddr  out  AW  RAM read address = {reg, word index}
- o_ren  out  1  RAM read strobe
- i_rdata  in  W  RAM read data, valid the cycle after o_ren
- o_waddr  out  AW  RAM write address
- o_wdata  out  W  RAM write data
- o_wen  out  1  RAM write strobe

## Operation
- Sequencer states: IDLE, RD1, RD2, RDY, STREAM.
- IDLE, i_rreq=1: latch rs1/rs2/rd addresses; go to RD1. i_rreq is ignored in any other state.
- RD1: o_ren=1, o_raddr={rs1,0}. Go to RD2.
- RD2: o_ren=1, o_raddr={rs2,0}. Capture i_rdata into rs1 shift register. Go to RDY.
- RDY: o_ready=1 for exactly this cycle. Capture i_rdata into rs2 shift register. Clear bit counter c. Go to STREAM.
- STREAM, per i_cnt_en cycle: o_rs1/o_rs2 are the shift-register LSBs; shift right; c increments. After c wraps 31->0, go to IDLE.
- Prefetch for word k+1 (k = c/W, k < 32/W-1):
  - at c%W==W-2: o_ren=1, o_raddr={rs1,k+1}; i_rdata loads the rs1 shift register at the end of cycle c%W==W-1.
  - at c%W==W-1: o_ren=1, o_raddr={rs2,k+1}.
  - in the next cycle (c%W==0, c!=0): o_rs2=i_rdata[0], and the rs2 shift register loads i_rdata>>1.
- Write path:
  - Bit i_wdata is placed at position c%W of the write buffer on every i_cnt_en cycle.
  - A sticky word-enable records any i_wen within the word.
  - Cycle after c%W==W-1 with word-enable set: o_wen=1, o_waddr={rd,c/W of completed word}, o_wdata=buffer. Word-enable then clears.
  - The final word is written one cycle after the last i_cnt_en.
- RAM is read-before-write on an address collision. Callers never assert i_rreq while i_cnt_en=1, so the pending final write always precedes the next RD1 read.
- Reset (asynchronous, any state, including mid-stream): state IDLE; c=0; shift registers, write buffer and word-enable cleared; all outputs 0. No o_wen issues after reset release until a new stream.

## Timing
- i_rreq to o_ready: 3 cycles (request sampled in cycle T; o_ready in cycle T+3).
- First stream bit is valid in the cycle after o_ready, qualified by i_cnt_en.
- While i_cnt_en=0 in STREAM, all state holds and no RAM reads issue. Stalls between bits are legal.
- RAM read bandwidth: 2 reads per W bits; no read in the first W-2 cycles of each word.
- o_ready is registered; o_rs2 is combinational from i_rdata only at word boundaries.

## Configuration
- SERV_RF_X0_GUARD_EN defined:
  - o_wen is never asserted when latched rd==0.
  - o_rs1/o_rs2 are forced 0 for the whole stream when the respective address is 0; RAM reads still issue.
- Undefined: x0 is treated as an ordinary register. RAM contents at x0 must be zero, and the caller must gate i_wen for rd==0.

## Test plan
- Reset mid-stream (W=4, c=13): assert i_rst_n=0 -> outputs 0 immediately; after release, no o_wen and o_ready=0 until next i_rreq.
- Read latency, W=2, RAM x5=0xA5A5_0F0F, x6=0x1234_5678: i_rreq with rs1=5, rs2=6 -> o_ready exactly 3 cycles later; 32 enabled cycles reproduce both values LSB first.
- Stalls, W=8: drop i_cnt_en on random cycles, including word boundaries c=7, 15 -> same serial output; reads only at c%8 in {6,7}.
- Write-back, W=4: rd=9, stream 0xDEADBEEF with i_wen=1 -> 8 writes, addresses {9,0..7}, data nibbles F,E,E,B,D,A,E,D; final write one cycle after last i_cnt_en.
- Back-to-back: write x3=0x55 then immediate i_rreq with rs1=3 -> o_rs1 streams 0x55 (no stale data).
- With SERV_RF_X0_GUARD_EN, RAM x0 preloaded 0xFFFFFFFF, rs1=0, rd=0, i_wen=1 -> o_rs1 all 0, o_wen never asserted. Without the macro -> o_rs1 streams 0xFFFFFFFF and writes occur.
